cic_decimator_multistage: RTL
=============================

Name: cic_decimator_multistage

Overview:
Parametrised Hogenauer CIC decimator. It has ORDER integrator stages at the input sample rate, a decimate-by-RATE counter, and ORDER comb stages with differential delay DIFF_DELAY at the output rate.
It succeeds the single-stage CIC downsampler and adds several things that block lacks: configurable order, one clock with a qualifying enable (no divided clock), synchronous reset, bit growth and output scaling, and a latency it guarantees.
It sits after the ADC/NCO front end and feeds the FIR compensation filter.

Parameters:
- width_H, 5: integer part width of data_i (signed).
- width_W, 20: fractional part width of data_i; input width WI = width_H+width_W.
- ORDER, 3: number of integrator stages and number of comb stages; allowed range 1..8.
- RATE, 32: decimation factor; allowed range 2..1024.
- DIFF_DELAY, 1: comb differential delay in decimated samples; allowed values 1 or 2.
- WIDTH_O, 0: output width; 0 means full precision WG = WI + ORDER*clog2(RATE*DIFF_DELAY).
- ROUND, 0: 0 truncates dropped LSBs; 1 rounds half-up.

Ports:
- clk, in, 1: single clock for all logic.
- rst, in, 1: synchronous, active-high reset.
- data_i_en, in, 1: input sample valid, one sample per asserted cycle.
- data_i, in, WI: signed two's-complement input sample.
- data_o_en, out, 1: one-cycle pulse per decimated output.
- data_o, out, WO: signed output, where WO = WG when WIDTH_O==0, else WIDTH_O.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Reset is sampled on the rising edge of clk and overrides all other activity in that cycle.
- Reset values: all integrators, comb registers, comb delay lines, the decimation counter and the comb valid pipeline clear to 0. data_o = 0 and data_o_en = 0.
- Arithmetic: every internal register is WG bits, signed. data_i is sign-extended to WG bits. All adds and subtracts wrap modulo 2^WG. Integrator overflow is expected and required to cancel in the combs; no saturation anywhere.
- Integrators: on each cycle with data_i_en=1, integ[0] += data_i and integ[k] += integ[k-1] (previous registered value). With data_i_en=0 all integrators hold.
- Decimation counter: range 0..RATE-1. It increments only on data_i_en=1 and wraps at RATE-1 back to 0. On the data_i_en=1 cycle where the count equals RATE-1, the next edge registers integ[ORDER-1] into comb stage 0 and asserts the comb valid for that stage.
- Combs: stage k updates only when its valid input is 1. It computes y = x - x_delayed and pushes x into a DIFF_DELAY-deep delay line. Valid moves forward one stage per clk.
- Output stage: one register stage.
  - With ROUND=0, data_o = the top WO bits of the WG-bit comb result.
  - With ROUND=1, 2^(WG-WO-1) is added before truncation, and the sum wraps.
  - When WO==WG, no rounding is applied.
- Latency: data_o_en pulses exactly ORDER+2 clk cycles after the edge that accepts every RATE-th sample. The pulse is one cycle wide and data_o holds until the next pulse.
- Gaps in data_i_en: gaps are allowed at any rate. The counter and integrators freeze during gaps, and the comb pipeline drains independently of data_i_en.
- Throughput: because RATE >= 2, the comb pipeline can never be overrun, and there is no back-pressure.
- DC gain is (RATE*DIFF_DELAY)^ORDER. The first ORDER*DIFF_DELAY outputs after reset are a transient response, not steady state.
- Reset mid-operation: any output in flight is discarded and data_o_en stays 0. The counter restarts, so the first post-reset output follows RATE accepted samples.
- Simultaneous rst and data_i_en: the sample is dropped.

Decomposition:
- Package cic_pkg holds:
  - the clog2 function;
  - the width function cic_width(WI, ORDER, RATE, DIFF_DELAY);
  - a signed WG-width typedef, parametrised inside the module via the package function.
- Sub-module cic_comb_stage: one comb stage with its delay line and valid in/out. It is instantiated ORDER times in a generate loop. The integrators remain inline in the top module.

Test Plan (common config width_H=3, width_W=5 so WI=8; ORDER=3, RATE=4, DIFF_DELAY=1; WIDTH_O=0 so WG=14):
1. Reset: hold rst 2 cycles while data_i_en=1 -> data_o=0 and data_o_en=0 throughout, and no pulse until 4 samples have been accepted after rst falls.
2. Constant data_i=1 with data_i_en=1 continuously -> data_o_en every 4 cycles; from the 4th output onward data_o=64. Each pulse arrives exactly 5 cycles after the edge accepting every 4th sample.
3. Constant data_i=-128 continuously -> integrators wrap while steady-state data_o=-8192 (0x2000 in 14 bits), proving modular cancellation.
4. data_i=1 with data_i_en asserted one cycle in three -> data_o_en spaced 12 cycles apart and steady data_o=64.
5. Reset pulse mid-run (after 10 outputs, 2 cycles into a decimation period) -> no data_o_en for the in-flight output; post-reset outputs repeat the transient, then reach 64.
6. WIDTH_O=9, ROUND=1, constant data_i=1 -> steady data_o=2. With ROUND=0 and WIDTH_O=8, constant data_i=3 -> steady data_o=3.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimator: ceiling log2, register-width
// calculation, and a signed accumulator type for the default configuration.
package cic_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 32'sd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Full-precision register width: every integrator and comb uses this width
  function automatic int cic_width(input int wi, input int order,
                                   input int rate, input int diff_delay);
    return wi + order * clog2(rate * diff_delay);
  endfunction

  localparam int CIC_WG_DEFAULT = cic_width(32'sd25, 32'sd3, 32'sd32, 32'sd1);
  typedef logic signed [CIC_WG_DEFAULT-1:0] cic_acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x delayed by DIFF_DELAY decimated samples,
// with a registered valid that follows the data one clock behind.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int WG         = 8,
  parameter int DIFF_DELAY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic signed [WG-1:0] x,
  output logic                 valid_out,
  output logic signed [WG-1:0] y
);

  logic signed [WG-1:0] dly_r [DIFF_DELAY];
  logic signed [WG-1:0] y_r;
  logic                 valid_r;

  // Difference and delay-line shift, advancing only on qualified samples
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIFF_DELAY; i++) begin
        dly_r[i] <= {WG{1'b0}};
      end
      y_r     <= {WG{1'b0}};
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_in;
      if (valid_in) begin
        y_r      <= x - dly_r[DIFF_DELAY-1];
        dly_r[0] <= x;
        for (int i = 1; i < DIFF_DELAY; i++) begin
          dly_r[i] <= dly_r[i-1];
        end
      end
    end
  end

  assign valid_out = valid_r;
  assign y         = y_r;

endmodule

// File: rtl/cic_decimator_multistage.sv
// Hogenauer CIC decimator: ORDER integrators at the input rate, decimate by
// RATE on a qualifying enable, ORDER comb stages, then an optional rescale.
module cic_decimator_multistage
  import cic_pkg::*;
#(
  parameter int width_H    = 5,
  parameter int width_W    = 20,
  parameter int ORDER      = 3,
  parameter int RATE       = 32,
  parameter int DIFF_DELAY = 1,
  parameter int WIDTH_O    = 0,
  parameter int ROUND      = 0,
  localparam int WI = width_H + width_W,
  localparam int WG = cic_width(WI, ORDER, RATE, DIFF_DELAY),
  localparam int WO = (WIDTH_O == 0) ? WG : WIDTH_O
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_i_en,
  input  logic signed [WI-1:0] data_i,
  output logic                 data_o_en,
  output logic signed [WO-1:0] data_o
);

  typedef logic signed [WG-1:0] acc_t;

  localparam int            CW       = clog2(RATE);
  localparam logic [CW-1:0] CNT_MAX  = CW'(RATE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  acc_t          data_ext_s;
  acc_t          integ_r [ORDER];
  logic [CW-1:0] cnt_r;
  logic          dec_pend_r;
  acc_t          cap_r;
  logic          cap_v_r;
  acc_t          comb_x_s [ORDER+1];
  logic          comb_v_s [ORDER+1];
  logic signed [WO-1:0] out_s;
  logic signed [WO-1:0] data_o_r;
  logic                 data_o_en_r;

  assign data_ext_s = acc_t'(data_i);

  // Integrator chain and decimation counter; both freeze while data_i_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_r[k] <= {WG{1'b0}};
      end
      cnt_r      <= CNT_ZERO;
      dec_pend_r <= 1'b0;
    end else begin
      dec_pend_r <= data_i_en && (cnt_r == CNT_MAX);
      if (data_i_en) begin
        integ_r[0] <= integ_r[0] + data_ext_s;
        for (int k = 1; k < ORDER; k++) begin
          integ_r[k] <= integ_r[k] + integ_r[k-1];
        end
        cnt_r <= (cnt_r == CNT_MAX) ? CNT_ZERO : (cnt_r + CNT_ONE);
      end
    end
  end

  // Capture the last integrator on the edge after every RATE-th accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_r   <= {WG{1'b0}};
      cap_v_r <= 1'b0;
    end else begin
      cap_v_r <= dec_pend_r;
      if (dec_pend_r) begin
        cap_r <= integ_r[ORDER-1];
      end
    end
  end

  assign comb_x_s[0] = cap_r;
  assign comb_v_s[0] = cap_v_r;

  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    cic_comb_stage #(
      .WG        (WG),
      .DIFF_DELAY(DIFF_DELAY)
    ) u_comb (
      .clk      (clk),
      .rst      (rst),
      .valid_in (comb_v_s[g]),
      .x        (comb_x_s[g]),
      .valid_out(comb_v_s[g+1]),
      .y        (comb_x_s[g+1])
    );
  end

  if (WO == WG) begin : g_full
    assign out_s = comb_x_s[ORDER];
  end else begin : g_scaled
    localparam int            SH      = WG - WO;
    localparam logic [WG-1:0] RND_INC = WG'(32'd1) << (SH - 1);
    logic [WG-1:0] sum_s;

    // Optional half-up rounding offset; the sum wraps in WG bits
    always_comb begin
      sum_s = comb_x_s[ORDER];
      if (ROUND != 0) begin
        sum_s = comb_x_s[ORDER] + RND_INC;
      end else begin
        sum_s = comb_x_s[ORDER];
      end
    end

    assign out_s = WO'(sum_s >> SH);
  end

  // Output register: one-cycle strobe, data held between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o_r    <= {WO{1'b0}};
      data_o_en_r <= 1'b0;
    end else begin
      data_o_en_r <= comb_v_s[ORDER];
      if (comb_v_s[ORDER]) begin
        data_o_r <= out_s;
      end
    end
  end

  assign data_o    = data_o_r;
  assign data_o_en = data_o_en_r;

endmodule
